// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared EasyAXI widths, encodings and read-responder FSM state type.
// Imported by the read responder and the address generator.
package easyaxi_rd_slv_pkg;

  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B   = 3'd0;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B   = 3'd1;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B   = 3'd3;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_16B  = 3'd4;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_32B  = 3'd5;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_128B = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rd_state_e;

  // Only 2, 4 and 8 beat wrapping bursts are accepted.
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7);
  endfunction

endpackage

// File: rtl/easyaxi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Shared between the read and write responders.
module easyaxi_addr_gen
  import easyaxi_rd_slv_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  addr,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_ADDR_W-1:0]  next_addr
);

  logic [AXI_ADDR_W-1:0] step;
  logic [AXI_ADDR_W-1:0] total;
  logic [AXI_ADDR_W-1:0] mask;
  logic [AXI_ADDR_W-1:0] incr_addr;

  always_comb begin
    step      = {{(AXI_ADDR_W-1){1'b0}}, 1'b1} << size;
    total     = ({{(AXI_ADDR_W-AXI_LEN_W){1'b0}}, len} + {{(AXI_ADDR_W-1){1'b0}}, 1'b1}) << size;
    mask      = total - {{(AXI_ADDR_W-1){1'b0}}, 1'b1};
    incr_addr = addr + step;
    next_addr = addr;
    case (burst)
      AXI_BURST_INCR: next_addr = incr_addr;
      AXI_BURST_WRAP: next_addr = (addr & ~mask) | (incr_addr & mask);
      default:        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// EasyAXI read responder: one AR at a time, returns arlen+1 beats from a
// constant word array (mem[i] = i) with SLVERR/DECERR classification.
module easyaxi_rd_slv
  import easyaxi_rd_slv_pkg::*;
#(
  parameter int MEM_DEPTH     = 64,
  parameter int MAX_BURST_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   axi_slv_arvalid,
  output logic                   axi_slv_arready,
  input  logic [AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                   axi_slv_rvalid,
  input  logic                   axi_slv_rready,
  output logic [AXI_ID_W-1:0]    axi_slv_rid,
  output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                   axi_slv_rlast
);

  localparam int DATA_BYTES_LOG2 = $clog2(AXI_DATA_W / 8);
  localparam int MEM_IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(MEM_DEPTH * (AXI_DATA_W / 8));

  rd_state_e state_reg, state_next;

  logic [AXI_ADDR_W-1:0]  addr_reg;
  logic [AXI_LEN_W-1:0]   len_reg;
  logic [AXI_SIZE_W-1:0]  size_reg;
  logic [AXI_BURST_W-1:0] burst_reg;
  logic                   slverr_reg;
  logic [AXI_LEN_W-1:0]   cnt_reg;
  logic [AXI_ID_W-1:0]    rid_reg;
  logic [AXI_DATA_W-1:0]  rdata_reg;
  logic [AXI_RESP_W-1:0]  rresp_reg;
  logic                   rlast_reg;

  logic                   arready_comb;
  logic                   rvalid_comb;
  logic                   ar_hs;
  logic                   r_hs;
  logic                   slverr_ar;
  logic [AXI_ADDR_W-1:0]  next_addr;
  logic [AXI_ADDR_W-1:0]  beat_addr;
  logic                   beat_slverr;
  logic                   beat_decerr;
  logic [MEM_IDX_W-1:0]   beat_idx;
  logic [AXI_DATA_W-1:0]  beat_data;
  logic [AXI_RESP_W-1:0]  beat_resp;

  // Read-only array: contents are fixed at the word index.
  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];
  generate
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_mem
      assign mem[gi] = AXI_DATA_W'(gi);
    end
  endgenerate

  easyaxi_addr_gen u_addr_gen (
    .addr      (addr_reg),
    .len       (len_reg),
    .size      (size_reg),
    .burst     (burst_reg),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    arready_comb = 1'b0;
    rvalid_comb  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        arready_comb = 1'b1;
        if (axi_slv_arvalid) state_next = ST_DATA;
      end
      ST_DATA: begin
        rvalid_comb = 1'b1;
        if (axi_slv_rready && rlast_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ar_hs = axi_slv_arvalid && arready_comb;
  assign r_hs  = axi_slv_rready && rvalid_comb;

  // Burst-level errors are judged once at AR accept and reused for every beat.
  assign slverr_ar = (int'(axi_slv_arlen) >= MAX_BURST_LEN)
                  || (int'(axi_slv_arsize) > DATA_BYTES_LOG2)
                  || ((axi_slv_arburst == AXI_BURST_WRAP) && !wrap_len_ok(axi_slv_arlen))
                  || (axi_slv_arburst == AXI_BURST_RSVD);

  always_comb begin
    beat_addr   = ar_hs ? axi_slv_araddr : next_addr;
    beat_slverr = ar_hs ? slverr_ar : slverr_reg;
    beat_decerr = !beat_slverr && (beat_addr >= MEM_BYTES);
    beat_idx    = beat_addr[DATA_BYTES_LOG2 +: MEM_IDX_W];
    beat_data   = (beat_slverr || beat_decerr) ? '0 : mem[beat_idx];
    beat_resp   = beat_slverr ? AXI_RESP_SLVERR :
                  beat_decerr ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      len_reg    <= '0;
      size_reg   <= '0;
      burst_reg  <= '0;
      slverr_reg <= 1'b0;
      cnt_reg    <= '0;
      rid_reg    <= '0;
      rdata_reg  <= '0;
      rresp_reg  <= AXI_RESP_OKAY;
      rlast_reg  <= 1'b0;
    end else if (ar_hs) begin
      addr_reg   <= axi_slv_araddr;
      len_reg    <= axi_slv_arlen;
      size_reg   <= axi_slv_arsize;
      burst_reg  <= axi_slv_arburst;
      slverr_reg <= slverr_ar;
      cnt_reg    <= '0;
      rid_reg    <= axi_slv_arid;
      rdata_reg  <= beat_data;
      rresp_reg  <= beat_resp;
      rlast_reg  <= (axi_slv_arlen == '0);
    end else if (r_hs) begin
      if (rlast_reg) begin
        rlast_reg <= 1'b0;
      end else begin
        addr_reg  <= next_addr;
        cnt_reg   <= cnt_reg + AXI_LEN_W'(1);
        rdata_reg <= beat_data;
        rresp_reg <= beat_resp;
        rlast_reg <= ((cnt_reg + AXI_LEN_W'(1)) == len_reg);
      end
    end
  end

  assign axi_slv_arready = arready_comb;
  assign axi_slv_rvalid  = rvalid_comb;
  assign axi_slv_rid     = rid_reg;
  assign axi_slv_rdata   = rdata_reg;
  assign axi_slv_rresp   = rresp_reg;
  assign axi_slv_rlast   = rlast_reg;

endmodule

// File: doc/easyaxi_rd_slv.md
# easyaxi_rd_slv

AXI read-channel responder (AR/R) pairing with the EasyAXI read master. It accepts one read request at a time and returns `arlen+1` beats from an internal word array. It supports FIXED, INCR and WRAP bursts up to 8 beats and flags unsupported or out-of-range requests with SLVERR or DECERR. It sits at the slave end of the EasyAXI read path as the bench target and reference responder.

## Interface
- MEM_DEPTH, 64: number of `AXI_DATA_W`-bit words in the internal array; power of 2.
- MAX_BURST_LEN, 8: longest supported burst, in beats.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- axi_slv_arvalid  in  1  request valid.
- axi_slv_arready  out  1  request accept.
- axi_slv_arid  in  `AXI_ID_W`  request ID.
- axi_slv_araddr  in  `AXI_ADDR_W`  start byte address.
- axi_slv_arlen  in  `AXI_LEN_W`  beats minus 1.
- axi_slv_arsize  in  `AXI_SIZE_W`  bytes per beat, log2.
- axi_slv_arburst  in  `AXI_BURST_W`  FIXED/INCR/WRAP.
- axi_slv_rvalid  out  1  beat valid.
- axi_slv_rready  in  1  beat accept.
- axi_slv_rid  out  `AXI_ID_W`  echoes the captured arid.
- axi_slv_rdata  out  `AXI_DATA_W`  beat data.
- axi_slv_rresp  out  `AXI_RESP_W`  OKAY/SLVERR/DECERR.
- axi_slv_rlast  out  1  final beat.

## Operation
- FSM states:
  - IDLE: arready=1.
  - DATA: rvalid=1, arready=0.
- Transitions:
  - IDLE→DATA on arvalid&arready. Capture id, addr, len, size and burst; clear the beat counter.
  - DATA→DATA on a non-last rvalid&rready. Advance the address, beat counter +1.
  - DATA→IDLE on rvalid&rready&rlast.
- Array reset contents: mem[i] = i, zero-extended. No write path; the array is constant after reset.
- Word index = addr >> log2(`AXI_DATA_W`/8), truncated to log2(MEM_DEPTH) bits.
- Next-address rules, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: total = (len+1)*step; base = addr & ~(total-1); next = base | ((addr+step) & (total-1)).
- Error classification, decided once at AR accept and applied to every beat of the burst:
  - SLVERR if len+1 > MAX_BURST_LEN.
  - SLVERR if size > log2(`AXI_DATA_W`/8).
  - SLVERR if burst is WRAP and len ∉ {1,3,7}.
  - SLVERR if burst is the reserved encoding.
- Address check, per beat, only when no SLVERR: beat address ≥ MEM_DEPTH*(`AXI_DATA_W`/8) → DECERR.
- Error beats: rdata=0.
- An errored burst still returns exactly len+1 beats. rlast is asserted on beat len, counted with a full `AXI_LEN_W` counter, so len up to 255 is tolerated.
- rlast = (beat_cnt == captured len).

## Timing
- Reset values:
  - axi_slv_arready=1, axi_slv_rvalid=0, axi_slv_rlast=0.
  - axi_slv_rid=0, axi_slv_rdata=0, axi_slv_rresp=OKAY (2'b00).
  - State=IDLE.
- All R outputs are registered.
- First rvalid rises the cycle after the AR handshake (1-cycle latency).
- Each beat:
  - With rready high, a new beat is presented every cycle.
  - With rready low, rid/rdata/rresp/rlast are held stable and rvalid stays high; rvalid never drops mid-burst.
- After the last handshake: rvalid=0 and arready=1 in the next cycle. No back-to-back AR accept in the same cycle as rlast; there is a 1-cycle bubble between bursts.
- Only one outstanding request; arready is low for the whole of DATA.
- A reset asserted mid-burst aborts immediately: outputs return to their reset values and the array contents are reinitialised.
- Address arithmetic is carried out in `AXI_ADDR_W` bits. INCR wraps modulo 2^`AXI_ADDR_W`; the beat that wraps past the array range gets DECERR.

## Structure
- Shared define file (existing EasyAXI defines):
  - `AXI_*_W` widths.
  - `AXI_BURST_FIXED/INCR/WRAP`.
  - `AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR`.
  - `AXI_SIZE_*`.
- The new localparams DATA_BYTES_LOG2 and MEM_IDX_W stay local to the block.
- Sub-module easyaxi_addr_gen: purely combinational next-address calculation from (addr, len, size, burst). It is reused later by the write responder.

## Test plan
- INCR: araddr=0x10, arlen=3, size=4B, rready=1 → rdata 4,5,6,7 on consecutive cycles; rlast on the 4th; rresp=OKAY; rid=arid.
- WRAP: araddr=0x34, arlen=3 → 0xD,0xE,0xF,0xC. Then WRAP: araddr=0x38, arlen=7 → 0xE,0xF,0x8..0xD.
- FIXED: araddr=0x30, arlen=3 → 0xC four times, rlast on the 4th.
- arlen=8 → 9 beats with SLVERR and rdata=0. araddr=0x100 (MEM_DEPTH=64) arlen=0 → 1 beat with DECERR.
- Random rready toggling during an 8-beat INCR → outputs are stable while stalled; no beat is lost or duplicated; arready stays low until the cycle after rlast.
- rst_n pulsed after beat 2 of an 8-beat burst → rvalid=0 and arready=1 immediately; the next request is served correctly from beat 0.
